err_inj_sequencer: RTL and testbench
====================================

// Module: err_inj_sequencer
// PURPOSE
//  Initiator side of the error-injection control bus. Accepts injection commands
//  over a valid/ready port, then drives err_en/err_ctrl onto the bus that feeds the
//  per-region control routers: target ID after a programmable delay, for a
//  programmable pulse length, repeated with a programmable gap. Sits between the
//  host/parser and the top-level router tree.
// PARAMETERS
//  ID_W    16       width of err_ctrl / cmd_id
//  DLY_W   16       width of delay and gap counters
//  LEN_W   8        width of pulse-length field
//  RPT_W   8        width of repeat field
//  MAX_ID  16'hFFFE highest legal target ID; larger IDs are rejected
//  IDLE_ID 16'hFFFF value driven on err_ctrl when no command is active
//  STAT_W  32       width of the injected-cycle statistics counter
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      asynchronous active-low reset
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      sequencer can accept (IDLE and !abort)
//  cmd_id      in   ID_W   target local-DFF ID
//  cmd_delay   in   DLY_W  cycles from accept to first pulse
//  cmd_len     in   LEN_W  err_en cycles per burst (0 treated as 1)
//  cmd_repeat  in   RPT_W  total bursts (0 treated as 1)
//  cmd_gap     in   DLY_W  err_en-low cycles between bursts
//  abort       in   1      cancel current command
//  err_en      out  1      injection enable to router tree (registered)
//  err_ctrl    out  ID_W   target ID to router tree (registered)
//  busy        out  1      command in progress
//  done        out  1      1-cycle pulse: command completed normally
//  aborted     out  1      1-cycle pulse: command cancelled by abort
//  cmd_err     out  1      1-cycle pulse: cmd_id > MAX_ID, command dropped
//  inj_count   out  STAT_W saturating count of err_en-high cycles since reset
// BEHAVIOUR
//  Reset: state IDLE; err_en=0, err_ctrl=IDLE_ID, busy/done/aborted/cmd_err=0,
//   inj_count=0, cmd_ready=1 after reset release. All outputs registered.
//  Accept at cycle T when cmd_valid&cmd_ready; fields latched at T.
//  FSM: IDLE -> WAIT (accept, legal ID) -> INJECT -> GAP -> INJECT ... -> IDLE.
//   WAIT: counts cmd_delay cycles; delay=0 goes straight to INJECT.
//   INJECT: err_en=1 for max(len,1) cycles. First err_en cycle = T+1+delay.
//   GAP: err_en=0 for gap cycles; gap=0 -> bursts back-to-back (err_en stays 1).
//   After final burst -> IDLE; done=1 and cmd_ready=1 in the cycle after the last
//   err_en cycle; a new command may be accepted that same cycle.
//  err_ctrl = latched ID from T+1 until return to IDLE, else IDLE_ID; it never
//   changes while err_en=1.
//  Illegal ID (> MAX_ID): accepted, cmd_err pulses at T+1, state stays IDLE,
//   err_en never asserted.
//  abort: in any non-IDLE state -> IDLE next cycle, err_en=0, err_ctrl=IDLE_ID,
//   aborted pulses, no done. abort in IDLE: no effect, cmd_ready=0 that cycle
//   (abort beats simultaneous cmd_valid).
//  busy = (state != IDLE). inj_count += 1 each err_en cycle, saturates at all-ones.
//  Async reset mid-command: immediate return to reset values, no done/aborted.
// CONFIGURATION
//  ERR_INJ_TRIG_EN defined: adds input trig (1 bit); WAIT holds (delay counter
//   frozen, no pulses) until trig sampled high, then counts cmd_delay. abort still
//   exits. Undefined: no trig port; delay countdown starts at T+1.
// TESTING
//  id=5,delay=0,len=1,rpt=1 accept T -> err_en=1,err_ctrl=5 at T+1; done at T+2.
//  id=3,delay=4,len=3,rpt=2,gap=2 -> err_en high T+5..7 and T+10..12; done T+13;
//   inj_count +6.
//  id=7,len=2,rpt=3,gap=0 -> err_en continuous 6 cycles, err_ctrl=7 throughout.
//  id=16'hFFFF -> cmd_err at T+1, err_en stays 0, cmd_ready high next cycle.
//  abort during 2nd burst -> err_en=0, err_ctrl=IDLE_ID, aborted next cycle, no done.
//  ERR_INJ_TRIG_EN, delay=2: trig at T+10 -> first err_en at T+13; none before.

Source files
------------

// File: rtl/err_inj_if.sv
// Error-injection control bus: command port from the host/parser and the
// err_en/err_ctrl drive toward the router tree, plus status.
// Handshake: a command transfers at a rising clk edge where cmd_valid and
// cmd_ready are both high; the fields must be stable while cmd_valid is high.
interface err_inj_if #(
   parameter int ID_W   = 16,
   parameter int DLY_W  = 16,
   parameter int LEN_W  = 8,
   parameter int RPT_W  = 8,
   parameter int STAT_W = 32
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ID_W-1:0]   cmd_id;
   logic [DLY_W-1:0]  cmd_delay;
   logic [LEN_W-1:0]  cmd_len;
   logic [RPT_W-1:0]  cmd_repeat;
   logic [DLY_W-1:0]  cmd_gap;
   logic              abort;
   logic              err_en;
   logic [ID_W-1:0]   err_ctrl;
   logic              busy;
   logic              done;
   logic              aborted;
   logic              cmd_err;
   logic [STAT_W-1:0] inj_count;

   modport master (
      input  cmd_valid, cmd_id, cmd_delay, cmd_len, cmd_repeat, cmd_gap, abort,
      output cmd_ready, err_en, err_ctrl, busy, done, aborted, cmd_err, inj_count
   );

   modport slave (
      output cmd_valid, cmd_id, cmd_delay, cmd_len, cmd_repeat, cmd_gap, abort,
      input  cmd_ready, err_en, err_ctrl, busy, done, aborted, cmd_err, inj_count
   );
endinterface

// File: rtl/err_inj_sequencer.sv
// Error-injection sequencer: accepts a command, waits a delay, then drives
// err_en with the target ID on err_ctrl for len cycles, repeated with a gap.
// Optional feature macro ERR_INJ_TRIG_EN: adds a trig input; the delay
// countdown only starts after trig has been sampled high.
module err_inj_sequencer #(
   parameter int ID_W   = 16,
   parameter int DLY_W  = 16,
   parameter int LEN_W  = 8,
   parameter int RPT_W  = 8,
   parameter int STAT_W = 32,
   parameter logic [ID_W-1:0] MAX_ID  = ID_W'(16'hFFFE),
   parameter logic [ID_W-1:0] IDLE_ID = ID_W'(16'hFFFF)
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef ERR_INJ_TRIG_EN
   input  logic       trig,
`endif
   err_inj_if.master  bus,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_INJECT, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [DLY_W-1:0]  cnt_q, cnt_d;
   logic [RPT_W-1:0]  rpt_q, rpt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [DLY_W-1:0]  gap_q, gap_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              armed_q, armed_d;
   logic              done_d, aborted_d, cmd_err_d;
   logic              accept;
   logic [LEN_W-1:0]  len_in;
   logic [RPT_W-1:0]  rpt_in;
   logic [DLY_W-1:0]  burst_cnt;

   // Ready only when idle; a concurrent abort blocks acceptance.
   assign bus.cmd_ready = (state_q == S_IDLE) && !bus.abort;
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign len_in        = (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
   assign rpt_in        = (bus.cmd_repeat == '0) ? RPT_W'(1) : bus.cmd_repeat;
   // Counter reload for one burst, taken from the latched length.
   assign burst_cnt     = DLY_W'(len_q - LEN_W'(1));
   assign dbg_state     = state_q;

   // Next-state logic: counters run to zero, then the phase advances.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rpt_d     = rpt_q;
      len_d     = len_q;
      gap_d     = gap_q;
      id_d      = id_q;
      armed_d   = armed_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      cmd_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (bus.cmd_id > MAX_ID) begin
                  cmd_err_d = 1'b1;
               end else begin
                  id_d    = bus.cmd_id;
                  len_d   = len_in;
                  gap_d   = bus.cmd_gap;
                  rpt_d   = rpt_in - RPT_W'(1);
                  armed_d = 1'b0;
`ifdef ERR_INJ_TRIG_EN
                  state_d = S_WAIT;
                  cnt_d   = bus.cmd_delay;
`else
                  if (bus.cmd_delay == '0) begin
                     state_d = S_INJECT;
                     cnt_d   = DLY_W'(len_in - LEN_W'(1));
                  end else begin
                     state_d = S_WAIT;
                     cnt_d   = bus.cmd_delay - DLY_W'(1);
                  end
`endif
               end
            end
         end
         S_WAIT: begin
`ifdef ERR_INJ_TRIG_EN
            // Before trig, cnt holds the full delay; after, the last count is 1.
            if (!armed_q) begin
               if (trig) begin
                  armed_d = 1'b1;
                  if (cnt_q == '0) begin
                     state_d = S_INJECT;
                     cnt_d   = burst_cnt;
                  end
               end
            end else if (cnt_q <= DLY_W'(1)) begin
               state_d = S_INJECT;
               cnt_d   = burst_cnt;
            end else begin
               cnt_d = cnt_q - DLY_W'(1);
            end
`else
            if (cnt_q == '0) begin
               state_d = S_INJECT;
               cnt_d   = burst_cnt;
            end else begin
               cnt_d = cnt_q - DLY_W'(1);
            end
`endif
         end
         S_INJECT: begin
            if (cnt_q == '0) begin
               if (rpt_q == '0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  rpt_d = rpt_q - RPT_W'(1);
                  if (gap_q == '0) begin
                     cnt_d = burst_cnt;
                  end else begin
                     state_d = S_GAP;
                     cnt_d   = gap_q - DLY_W'(1);
                  end
               end
            end else begin
               cnt_d = cnt_q - DLY_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               state_d = S_INJECT;
               cnt_d   = burst_cnt;
            end else begin
               cnt_d = cnt_q - DLY_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort wins over any progress in an active command.
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         aborted_d = 1'b1;
         done_d    = 1'b0;
      end
   end

   // State, command registers and registered bus outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         rpt_q        <= '0;
         len_q        <= '0;
         gap_q        <= '0;
         id_q         <= '0;
         armed_q      <= 1'b0;
         bus.err_en   <= 1'b0;
         bus.err_ctrl <= IDLE_ID;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.aborted  <= 1'b0;
         bus.cmd_err  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rpt_q        <= rpt_d;
         len_q        <= len_d;
         gap_q        <= gap_d;
         id_q         <= id_d;
         armed_q      <= armed_d;
         bus.err_en   <= (state_d == S_INJECT);
         bus.err_ctrl <= (state_d != S_IDLE) ? id_d : IDLE_ID;
         bus.busy     <= (state_d != S_IDLE);
         bus.done     <= done_d;
         bus.aborted  <= aborted_d;
         bus.cmd_err  <= cmd_err_d;
      end
   end

   // Saturating count of cycles with err_en high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.inj_count <= '0;
      end else if (bus.err_en && (bus.inj_count != '1)) begin
         bus.inj_count <= bus.inj_count + STAT_W'(1);
      end
   end

endmodule

// File: tb/tb_err_inj_sequencer.sv
// Directed bench for err_inj_sequencer: a table of commands with hand-derived
// timing, plus sequences for abort, abort-in-idle and async reset.
module tb_err_inj_sequencer;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;
`ifdef ERR_INJ_TRIG_EN
   logic       trig;
`endif

   int checks;
   int errors;

   err_inj_if bus_if ();

   err_inj_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef ERR_INJ_TRIG_EN
      .trig      (trig),
`endif
      .bus       (bus_if.master),
      .dbg_state (dbg_state)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] id;
      logic [15:0] dly;
      logic [7:0]  len;
      logic [7:0]  rpt;
      logic [15:0] gap;
      int          exp_first;  // cycle offset of first err_en (0 = never)
      int          exp_ones;   // err_en-high cycles
      int          exp_done;   // cycle offset of done (0 = never)
      int          exp_err;    // cycle offset of cmd_err (0 = never)
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_cmd(input logic [15:0] id, input logic [15:0] dly,
                            input logic [7:0] len, input logic [7:0] rpt,
                            input logic [15:0] gap);
      bus_if.cmd_valid  = 1'b1;
      bus_if.cmd_id     = id;
      bus_if.cmd_delay  = dly;
      bus_if.cmd_len    = len;
      bus_if.cmd_repeat = rpt;
      bus_if.cmd_gap    = gap;
   endtask

   initial begin
      int first, ones, done_at, err_at, bad_ctrl, busy1, aborted_seen, done_seen;
      logic [31:0] cnt0;
      checks = 0;
      errors = 0;
      vecs[0] = '{16'd5,     16'd0, 8'd1, 8'd1, 16'd0, 1, 1, 2, 0};
      vecs[1] = '{16'd3,     16'd4, 8'd3, 8'd2, 16'd2, 5, 6, 13, 0};
      vecs[2] = '{16'd7,     16'd0, 8'd2, 8'd3, 16'd0, 1, 6, 7, 0};
      vecs[3] = '{16'hFFFF,  16'd2, 8'd1, 8'd1, 16'd0, 0, 0, 0, 1};
      vecs[4] = '{16'd1,     16'd1, 8'd0, 8'd0, 16'd5, 2, 1, 3, 0};
      vecs[5] = '{16'hFFFE,  16'd2, 8'd1, 8'd2, 16'd1, 3, 2, 6, 0};
      vecs[6] = '{16'd0,     16'd0, 8'd2, 8'd2, 16'd3, 1, 4, 8, 0};

      // Reset
      rst_n = 1'b0;
      bus_if.abort = 1'b0;
      drive_cmd(16'd0, 16'd0, 8'd0, 8'd0, 16'd0);
      bus_if.cmd_valid = 1'b0;
`ifdef ERR_INJ_TRIG_EN
      trig = 1'b1;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_err_en",    32'(bus_if.err_en), 32'd0);
      check("rst_err_ctrl",  32'(bus_if.err_ctrl), 32'hFFFF);
      check("rst_busy",      32'(bus_if.busy), 32'd0);
      check("rst_done",      32'(bus_if.done), 32'd0);
      check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
      check("rst_inj_count", bus_if.inj_count, 32'd0);

      // Table-driven commands
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         cnt0 = bus_if.inj_count;
         drive_cmd(vecs[i].id, vecs[i].dly, vecs[i].len, vecs[i].rpt, vecs[i].gap);
         check($sformatf("v%0d_ready", i), 32'(bus_if.cmd_ready), 32'd1);
         first = 0; ones = 0; done_at = 0; err_at = 0; bad_ctrl = 0; busy1 = 0;
         for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
               bus_if.cmd_valid = 1'b0;
               busy1 = int'(bus_if.busy);
            end
            if (bus_if.err_en) begin
               ones++;
               if (first == 0) first = k;
               if (bus_if.err_ctrl !== vecs[i].id) bad_ctrl++;
            end
            if (bus_if.done && done_at == 0) done_at = k;
            if (bus_if.cmd_err && err_at == 0) err_at = k;
         end
         check($sformatf("v%0d_first_en", i), 32'(first), 32'(vecs[i].exp_first));
         check($sformatf("v%0d_en_cycles", i), 32'(ones), 32'(vecs[i].exp_ones));
         check($sformatf("v%0d_done_at", i), 32'(done_at), 32'(vecs[i].exp_done));
         check($sformatf("v%0d_cmd_err_at", i), 32'(err_at), 32'(vecs[i].exp_err));
         check($sformatf("v%0d_bad_ctrl", i), 32'(bad_ctrl), 32'd0);
         check($sformatf("v%0d_busy", i), 32'(busy1), (vecs[i].exp_err != 0) ? 32'd0 : 32'd1);
         check($sformatf("v%0d_inj_delta", i), bus_if.inj_count - cnt0, 32'(vecs[i].exp_ones));
      end

      // Abort during the second burst: bursts at T+1..3 and T+5..7
      @(negedge clk);
      drive_cmd(16'd9, 16'd0, 8'd3, 8'd3, 16'd1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) bus_if.cmd_valid = 1'b0;
      end
      check("abort_pre_en", 32'(bus_if.err_en), 32'd1);
      bus_if.abort = 1'b1;
      @(negedge clk);
      bus_if.abort = 1'b0;
      check("abort_err_en",   32'(bus_if.err_en), 32'd0);
      check("abort_err_ctrl", 32'(bus_if.err_ctrl), 32'hFFFF);
      check("abort_pulse",    32'(bus_if.aborted), 32'd1);
      check("abort_busy",     32'(bus_if.busy), 32'd0);
      done_seen = 0;
      aborted_seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus_if.done || bus_if.err_en) done_seen++;
         if (bus_if.aborted) aborted_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_one_pulse", 32'(aborted_seen), 32'd0);

      // Abort in idle beats a simultaneous command
      drive_cmd(16'd4, 16'd0, 8'd1, 8'd1, 16'd0);
      bus_if.abort = 1'b1;
      #1;
      check("idle_abort_ready", 32'(bus_if.cmd_ready), 32'd0);
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
      bus_if.abort = 1'b0;
      check("idle_abort_busy",    32'(bus_if.busy), 32'd0);
      check("idle_abort_aborted", 32'(bus_if.aborted), 32'd0);
      @(negedge clk);
      check("idle_abort_no_en", 32'(bus_if.err_en), 32'd0);

      // Async reset mid-command
      drive_cmd(16'd2, 16'd0, 8'd5, 8'd1, 16'd0);
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
      @(negedge clk);
      check("arst_pre_en", 32'(bus_if.err_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_err_en",    32'(bus_if.err_en), 32'd0);
      check("arst_err_ctrl",  32'(bus_if.err_ctrl), 32'hFFFF);
      check("arst_busy",      32'(bus_if.busy), 32'd0);
      check("arst_inj_count", bus_if.inj_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus_if.done || bus_if.aborted || bus_if.err_en) done_seen++;
      end
      check("arst_quiet", 32'(done_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
